sub_result_stage: RTL and testbench

- Registered output stage directly downstream of the subtractor.
- Captures the subtractor's SIZE+1-bit sign-extended difference and its overflow flag through a valid/ready handshake.
- Derives zero, negative and overflow flags, and buffers results in a 2-entry in-order skid buffer.
- Maintains a sticky overflow flag and a saturating overflow-event counter for the ALU status logic.

---
 rtl/sub_result_stage_if.sv | 51 +++++
 rtl/sub_result_stage.sv | 177 +++++++++++++++++
 tb/tb_sub_result_stage.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_result_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : sub_result_stage_if
// Description : Upstream/downstream handshake bundle for the subtractor
//               result stage (capture side and registered output side).
// Revision    : 1.0
// ============================================================================
interface sub_result_stage_if #(
    parameter int SIZE = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE:0]   in_result;
    logic            in_overflow;

    logic            out_valid;
    logic            out_ready;
    logic [SIZE:0]   out_result;
    logic            out_zero;
    logic            out_negative;
    logic            out_overflow;

    // Master is the environment around the stage: it feeds results in and
    // applies backpressure on the output side.
    modport master (
        output in_valid,
        output in_result,
        output in_overflow,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_zero,
        input  out_negative,
        input  out_overflow
    );

    modport slave (
        input  in_valid,
        input  in_result,
        input  in_overflow,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_zero,
        output out_negative,
        output out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/sub_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : sub_result_stage
// Description : Registered output stage behind the subtractor: flag capture,
//               2-entry in-order skid buffer, sticky overflow and counter.
// Revision    : 1.0
// ============================================================================
module sub_result_stage #(
    parameter int SIZE      = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sub_result_stage_if.slave    bus,
    input  logic                 clear_sticky,
    output logic                 sticky_overflow,
    output logic [CNT_WIDTH-1:0] ovf_count
);

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    // Entry layout: {result, overflow, zero, negative}
    localparam int c_ENTRY_W = SIZE + 4;

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 r_in_ready;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_head_from_in;
    logic                 w_head_from_tail;
    logic                 w_tail_load;
    logic                 w_out_valid;

    logic                 w_in_zero;
    logic                 w_in_negative;
    logic [c_ENTRY_W-1:0] w_in_entry;
    logic [c_ENTRY_W-1:0] r_head;
    logic [c_ENTRY_W-1:0] r_tail;

    logic                 w_ovf_xfer;
    logic                 r_sticky;
    logic [CNT_WIDTH-1:0] r_ovf_count;

    assign w_push = bus.in_valid && r_in_ready;
    assign w_pop  = (r_state != c_EMPTY) && bus.out_ready;

    // Flags are frozen at capture so the output side is a pure register read.
    assign w_in_zero     = (bus.in_result == '0);
    assign w_in_negative = bus.in_result[SIZE];
    assign w_in_entry    = {bus.in_result, bus.in_overflow, w_in_zero, w_in_negative};

    // ------------------------------------------------------------------
    // Occupancy state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != c_FULL);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_EMPTY: begin
                if (w_push) begin
                    w_state_next = c_ONE;
                end
            end
            c_ONE: begin
                if (w_push && !w_pop) begin
                    w_state_next = c_FULL;
                end else if (!w_push && w_pop) begin
                    w_state_next = c_EMPTY;
                end
            end
            c_FULL: begin
                if (w_pop) begin
                    w_state_next = c_ONE;
                end
            end
            default: begin
                w_state_next = c_EMPTY;
            end
        endcase
    end

    // A simultaneous push and pop in ONE bypasses the tail: the new entry
    // goes straight into the head register.
    always_comb begin
        w_head_from_in   = 1'b0;
        w_head_from_tail = 1'b0;
        w_tail_load      = 1'b0;
        w_out_valid      = 1'b0;
        case (r_state)
            c_EMPTY: begin
                w_head_from_in = w_push;
            end
            c_ONE: begin
                w_out_valid    = 1'b1;
                w_head_from_in = w_push && w_pop;
                w_tail_load    = w_push && !w_pop;
            end
            c_FULL: begin
                w_out_valid      = 1'b1;
                w_head_from_tail = w_pop;
            end
            default: begin
                w_out_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_head_from_in) begin
                r_head <= w_in_entry;
            end else if (w_head_from_tail) begin
                r_head <= r_tail;
            end
            if (w_tail_load) begin
                r_tail <= w_in_entry;
            end
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_result   = r_head[c_ENTRY_W-1:3];
    assign bus.out_overflow = r_head[2];
    assign bus.out_zero     = r_head[1];
    assign bus.out_negative = r_head[0];

    // ------------------------------------------------------------------
    // Sticky overflow and saturating event counter
    // ------------------------------------------------------------------
    assign w_ovf_xfer = w_push && bus.in_overflow;

    // A new overflow event outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky    <= 1'b0;
            r_ovf_count <= '0;
        end else if (w_ovf_xfer) begin
            r_sticky <= 1'b1;
            if (clear_sticky) begin
                r_ovf_count <= c_CNT_ONE;
            end else if (r_ovf_count != c_CNT_MAX) begin
                r_ovf_count <= r_ovf_count + c_CNT_ONE;
            end
        end else if (clear_sticky) begin
            r_sticky    <= 1'b0;
            r_ovf_count <= '0;
        end
    end

    assign sticky_overflow = r_sticky;
    assign ovf_count       = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_sub_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_result_stage
// Description : Directed bench for sub_result_stage with a queue-based model,
//               run on CNT_WIDTH=8 and CNT_WIDTH=2 instances in parallel.
// Revision    : 1.0
// ============================================================================
module tb_sub_result_stage;

    localparam int SIZE = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            clear_sticky;
    logic            in_valid;
    logic            in_overflow;
    logic            out_ready;
    logic [SIZE:0]   in_result;

    logic            sticky_a;
    logic            sticky_b;
    logic [7:0]      cnt_a;
    logic [1:0]      cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sub_result_stage_if #(.SIZE(SIZE)) bus_a ();
    sub_result_stage_if #(.SIZE(SIZE)) bus_b ();

    assign bus_a.in_valid    = in_valid;
    assign bus_a.in_result   = in_result;
    assign bus_a.in_overflow = in_overflow;
    assign bus_a.out_ready   = out_ready;
    assign bus_b.in_valid    = in_valid;
    assign bus_b.in_result   = in_result;
    assign bus_b.in_overflow = in_overflow;
    assign bus_b.out_ready   = out_ready;

    sub_result_stage #(.SIZE(SIZE), .CNT_WIDTH(8)) u_dut_a (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus_a.slave),
        .clear_sticky    (clear_sticky),
        .sticky_overflow (sticky_a),
        .ovf_count       (cnt_a)
    );

    sub_result_stage #(.SIZE(SIZE), .CNT_WIDTH(2)) u_dut_b (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus_b.slave),
        .clear_sticky    (clear_sticky),
        .sticky_overflow (sticky_b),
        .ovf_count       (cnt_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a FIFO of at most two results plus an unbounded
    // overflow-event tally that each counter width clips on its own.
    // ------------------------------------------------------------------
    logic [SIZE:0] mq_res[$];
    logic          mq_ovf[$];
    bit            m_ready  = 1'b0;
    bit            m_sticky = 1'b0;
    int            m_nov    = 0;

    function automatic int exp_cnt(input int w);
        int lim;
        lim = (1 << w) - 1;
        return (m_nov > lim) ? lim : m_nov;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mq_res.delete();
                mq_ovf.delete();
                m_ready  = 1'b0;
                m_sticky = 1'b0;
                m_nov    = 0;
            end else begin
                bit push;
                bit pop;
                push = in_valid && m_ready;
                pop  = (mq_res.size() != 0) && out_ready;
                if (pop) begin
                    void'(mq_res.pop_front());
                    void'(mq_ovf.pop_front());
                end
                if (push) begin
                    mq_res.push_back(in_result);
                    mq_ovf.push_back(in_overflow);
                end
                m_ready = (mq_res.size() != 2);
                if (push && in_overflow) begin
                    m_sticky = 1'b1;
                    m_nov    = clear_sticky ? 1 : m_nov + 1;
                end else if (clear_sticky) begin
                    m_sticky = 1'b0;
                    m_nov    = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("a_in_ready",  bus_a.in_ready,  m_ready);
            chk("b_in_ready",  bus_b.in_ready,  m_ready);
            chk("a_out_valid", bus_a.out_valid, mq_res.size() != 0);
            chk("b_out_valid", bus_b.out_valid, mq_res.size() != 0);
            chk("a_sticky",    sticky_a,        m_sticky);
            chk("b_sticky",    sticky_b,        m_sticky);
            chk("a_ovf_count", cnt_a,           exp_cnt(8));
            chk("b_ovf_count", cnt_b,           exp_cnt(2));
            if (mq_res.size() != 0) begin
                chk("a_out_result",   bus_a.out_result,   mq_res[0]);
                chk("b_out_result",   bus_b.out_result,   mq_res[0]);
                chk("a_out_zero",     bus_a.out_zero,     mq_res[0] == 0);
                chk("a_out_negative", bus_a.out_negative, mq_res[0][SIZE]);
                chk("a_out_overflow", bus_a.out_overflow, mq_ovf[0]);
                chk("b_out_overflow", bus_b.out_overflow, mq_ovf[0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    logic [SIZE:0] seen[$];

    initial begin
        int next;
        bit acc;
        reset_n      = 1'b0;
        clear_sticky = 1'b0;
        in_valid     = 1'b0;
        in_overflow  = 1'b0;
        in_result    = '0;
        out_ready    = 1'b0;

        @(negedge clk);
        chk("rst_out_valid",  bus_a.out_valid,  0);
        chk("rst_in_ready",   bus_a.in_ready,   0);
        chk("rst_out_result", bus_a.out_result, 0);
        chk("rst_out_ovf",    bus_a.out_overflow, 0);
        chk("rst_sticky",     sticky_a,         0);
        chk("rst_count",      cnt_a,            0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", bus_a.in_ready, 1);

        // 100 - (-100) overflows
        in_valid = 1'b1; in_result = 9'h0C8; in_overflow = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("t1_valid",    bus_a.out_valid,    1);
        chk("t1_result",   bus_a.out_result,   9'h0C8);
        chk("t1_negative", bus_a.out_negative, 0);
        chk("t1_zero",     bus_a.out_zero,     0);
        chk("t1_overflow", bus_a.out_overflow, 1);
        chk("t1_sticky",   sticky_a,           1);
        chk("t1_count",    cnt_a,              1);

        // 5-5 then 3-10 back to back
        in_result = 9'h000; in_overflow = 1'b0;
        @(negedge clk);
        chk("t2_zero",     bus_a.out_zero,   1);
        chk("t2_result",   bus_a.out_result, 9'h000);
        chk("t2_ready",    bus_a.in_ready,   1);
        in_result = 9'h1F9;
        @(negedge clk);
        chk("t2_negative", bus_a.out_negative, 1);
        chk("t2_zero_lo",  bus_a.out_zero,     0);
        chk("t2_result2",  bus_a.out_result,   9'h1F9);
        chk("t2_ready2",   bus_a.in_ready,     1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_drained", bus_a.out_valid, 0);

        // Backpressure: fill, refuse third, drain in order
        out_ready = 1'b0; in_valid = 1'b1; in_result = 9'h010;
        @(negedge clk);
        chk("t3_ready1", bus_a.in_ready, 1);
        in_result = 9'h020;
        @(negedge clk);
        chk("t3_ready_full", bus_a.in_ready,   0);
        chk("t3_head1",      bus_a.out_result, 9'h010);
        in_result = 9'h030;
        @(negedge clk);
        chk("t3_refused_ready", bus_a.in_ready,   0);
        chk("t3_head_hold",     bus_a.out_result, 9'h010);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("t3_head2",  bus_a.out_result, 9'h020);
        chk("t3_valid2", bus_a.out_valid,  1);
        @(negedge clk);
        chk("t3_empty",  bus_a.out_valid,  0);

        // Fill with 1,2 then stream 3..6 through a full buffer
        out_ready = 1'b0; in_valid = 1'b1; in_result = 9'd1;
        @(negedge clk);
        in_result = 9'd2;
        @(negedge clk);
        chk("t4_full", bus_a.in_ready, 0);
        out_ready = 1'b1;
        next = 3;
        for (int c = 0; c < 20 && seen.size() < 6; c++) begin
            in_valid  = (next <= 6);
            in_result = 9'(next);
            acc       = in_valid && m_ready;
            if (bus_a.out_valid) seen.push_back(bus_a.out_result);
            @(negedge clk);
            if (acc) next++;
        end
        in_valid = 1'b0;
        chk("t4_count", seen.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < seen.size()) chk("t4_order", seen[i], i + 1);
        end

        // Clear, two overflows, then clear together with a third overflow
        clear_sticky = 1'b1;
        @(negedge clk);
        chk("t5_cleared_sticky", sticky_a, 0);
        chk("t5_cleared_count",  cnt_a,    0);
        clear_sticky = 1'b0;
        in_valid = 1'b1; in_overflow = 1'b1; in_result = 9'h080;
        @(negedge clk);
        @(negedge clk);
        chk("t5_count2", cnt_a, 2);
        clear_sticky = 1'b1;
        @(negedge clk);
        chk("t5_set_wins_sticky", sticky_a, 1);
        chk("t5_set_wins_count",  cnt_a,    1);
        chk("t5_set_wins_count2", cnt_b,    1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_clear_sticky", sticky_a, 0);
        chk("t5_clear_count",  cnt_a,    0);
        clear_sticky = 1'b0;

        // Saturation on the narrow counter, then reset while full
        in_valid = 1'b1; in_overflow = 1'b1; in_result = 9'h081;
        repeat (5) @(negedge clk);
        chk("t6_sat_narrow", cnt_b, 3);
        chk("t6_wide",       cnt_a, 5);
        out_ready = 1'b0; in_overflow = 1'b0; in_result = 9'h042;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_full_ready", bus_a.in_ready,  0);
        chk("t6_full_valid", bus_a.out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_valid",  bus_a.out_valid, 0);
        chk("t6_rst_ready",  bus_a.in_ready,  0);
        chk("t6_rst_cnt_a",  cnt_a,           0);
        chk("t6_rst_cnt_b",  cnt_b,           0);
        chk("t6_rst_sticky", sticky_b,        0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_again", bus_a.in_ready,  1);
        chk("t6_still_empty", bus_a.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
